// File: rtl/setup_controller.sv
// Clock setup mode controller: field selection, auto-repeat adjust strobes
// and idle timeout back to run mode.
module setup_controller #(
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter int unsigned REPEAT_CYC  = 10_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode,
    input  logic btn_next,
    input  logic btn_inc,
    input  logic btn_dec,
    output logic display,
    output logic setup_sec,
    output logic setup_min,
    output logic setup_hour,
    output logic setup_day,
    output logic setup_month,
    output logic setup_year,
    output logic inc_dec,
    output logic tick
);

    typedef enum logic [2:0] {
        RUN, S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR
    } state_t;

    localparam logic [31:0] HOLD_LIM = 32'(HOLD_CYC);
    localparam logic [31:0] REP_LIM  = 32'(REPEAT_CYC);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_n;
    logic [31:0] rep_cnt;
    logic [31:0] idle_cnt;
    logic        rep_phase;
    logic        prev_ok;
    logic        prev_inc;
    logic        prev_dec;

    logic moving;
    logic active;
    logic same;
    logic first;
    logic rep_hit;
    logic tick_n;
    logic any_btn;

    always_comb begin
        state_n = state;
        if (state == RUN) begin
            if (btn_mode) state_n = S_SEC;
        end else if (btn_mode || idle_cnt == TO_LAST) begin
            state_n = RUN;
        end else if (btn_next) begin
            unique case (state)
                S_SEC:   state_n = S_MIN;
                S_MIN:   state_n = S_HOUR;
                S_HOUR:  state_n = S_DAY;
                S_DAY:   state_n = S_MON;
                S_MON:   state_n = S_YEAR;
                S_YEAR:  state_n = S_SEC;
                default: state_n = RUN;
            endcase
        end
    end

    always_comb begin
        display     = (state != RUN);
        setup_sec   = (state != S_SEC);
        setup_min   = (state != S_MIN);
        setup_hour  = (state != S_HOUR);
        setup_day   = (state != S_DAY);
        setup_month = (state != S_MON);
        setup_year  = (state != S_YEAR);
    end

    // A held button is "the same press" only if nothing changed since last
    // cycle, including the field; otherwise it restarts as a first press.
    always_comb begin
        moving  = (state_n != state);
        active  = (state != RUN) && !moving && (btn_inc ^ btn_dec);
        same    = prev_ok && (prev_inc == btn_inc) && (prev_dec == btn_dec);
        first   = active && !same;
        rep_hit = active && same &&
                  (rep_phase ? (rep_cnt == REP_LIM) : (rep_cnt == HOLD_LIM));
        tick_n  = (first || rep_hit) && !tick;
        any_btn = btn_mode || btn_next || btn_inc || btn_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            tick      <= 1'b0;
            inc_dec   <= 1'b1;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            idle_cnt  <= '0;
            prev_ok   <= 1'b0;
            prev_inc  <= 1'b0;
            prev_dec  <= 1'b0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            prev_ok  <= !moving;
            prev_inc <= btn_inc;
            prev_dec <= btn_dec;
            if (tick_n) inc_dec <= btn_inc;

            if (!active) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
            end else if (first || rep_hit) begin
                rep_cnt   <= 32'd1;
                rep_phase <= rep_hit;
            end else begin
                rep_cnt <= rep_cnt + 32'd1;
            end

            if (state == RUN || any_btn) idle_cnt <= '0;
            else                         idle_cnt <= idle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_setup_controller.sv
// Directed bench for setup_controller with a per-cycle expectation queue.
// Field selects are checked as {sec,min,hour,day,month,year}.
module tb_setup_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_next = 1'b0;
    logic btn_inc = 1'b0;
    logic btn_dec = 1'b0;
    logic display;
    logic setup_sec, setup_min, setup_hour;
    logic setup_day, setup_month, setup_year;
    logic inc_dec;
    logic tick;

    setup_controller #(
        .HOLD_CYC(8), .REPEAT_CYC(3), .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next),
        .btn_inc(btn_inc), .btn_dec(btn_dec),
        .display(display),
        .setup_sec(setup_sec), .setup_min(setup_min),
        .setup_hour(setup_hour), .setup_day(setup_day),
        .setup_month(setup_month), .setup_year(setup_year),
        .inc_dec(inc_dec), .tick(tick)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] SR = 6'b111111;
    localparam logic [5:0] SS = 6'b011111;
    localparam logic [5:0] SM = 6'b101111;
    localparam logic [5:0] SH = 6'b110111;
    localparam logic [5:0] SD = 6'b111011;
    localparam logic [5:0] SO = 6'b111101;
    localparam logic [5:0] SY = 6'b111110;

    typedef struct {
        logic       disp;
        logic [5:0] sel;
        logic       tk;
        logic       id;
        logic       chk_id;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;

    // Drive one cycle of inputs, queue what the outputs must be after the edge.
    task automatic cyc(input logic r, input logic m, input logic n,
                       input logic i, input logic d,
                       input logic [5:0] es, input logic et,
                       input logic eid, input logic cid, input string tag);
        exp_t e;
        exp_t g;
        logic [5:0] sel;
        e.disp = (es != SR);
        e.sel = es;
        e.tk = et;
        e.id = eid;
        e.chk_id = cid;
        e.tag = tag;
        q.push_back(e);
        rst = r; btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d;
        @(posedge clk);
        #1;
        g = q.pop_front();
        sel = {setup_sec, setup_min, setup_hour,
               setup_day, setup_month, setup_year};
        vecs++;
        assert (display === g.disp) else begin
            errs++;
            $error("FAIL %s display got %0b exp %0b", g.tag, display, g.disp);
        end
        vecs++;
        assert (sel === g.sel) else begin
            errs++;
            $error("FAIL %s sel got %b exp %b", g.tag, sel, g.sel);
        end
        vecs++;
        assert (tick === g.tk) else begin
            errs++;
            $error("FAIL %s tick got %0b exp %0b", g.tag, tick, g.tk);
        end
        if (g.chk_id) begin
            vecs++;
            assert (inc_dec === g.id) else begin
                errs++;
                $error("FAIL %s inc_dec got %0b exp %0b", g.tag, inc_dec, g.id);
            end
        end
    endtask

    task automatic idle(input logic [5:0] es, input string tag);
        cyc(0, 0, 0, 0, 0, es, 0, 0, 0, tag);
    endtask

    function automatic logic in_set(input int c, input int s[5]);
        foreach (s[k]) if (s[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int inc_ticks[5];
        int yr_ticks[5];
        logic t;
        inc_ticks = '{1, 9, 12, 15, 18};
        yr_ticks  = '{1, 9, 12, -1, -1};

        // reset
        cyc(1, 0, 0, 0, 0, SR, 0, 1, 1, "reset0");
        cyc(1, 0, 0, 0, 0, SR, 0, 1, 1, "reset1");
        idle(SR, "run_idle");

        // enter setup, stay idle ten cycles
        cyc(0, 1, 0, 0, 0, SS, 0, 0, 0, "enter");
        for (int k = 0; k < 10; k++) idle(SS, "sec_idle");

        // field walk, then mode+next together
        cyc(0, 0, 1, 0, 0, SM, 0, 0, 0, "next_min");
        cyc(0, 0, 1, 0, 0, SH, 0, 0, 0, "next_hour");
        cyc(0, 0, 1, 0, 0, SD, 0, 0, 0, "next_day");
        cyc(0, 0, 1, 0, 0, SO, 0, 0, 0, "next_mon");
        cyc(0, 0, 1, 0, 0, SY, 0, 0, 0, "next_year");
        cyc(0, 0, 1, 0, 0, SS, 0, 0, 0, "next_wrap");
        cyc(0, 1, 1, 0, 0, SR, 0, 0, 0, "mode_wins");
        cyc(0, 0, 1, 0, 0, SR, 0, 0, 0, "next_in_run");

        // auto-repeat on increment in S_MIN
        cyc(0, 1, 0, 0, 0, SS, 0, 0, 0, "enter2");
        cyc(0, 0, 1, 0, 0, SM, 0, 0, 0, "to_min");
        idle(SM, "min_idle");
        for (int k = 0; k < 20; k++) begin
            t = in_set(k + 1, inc_ticks);
            cyc(0, 0, 0, 1, 0, SM, t, 1, t, "inc_hold");
        end
        for (int k = 0; k < 5; k++) idle(SM, "inc_rel");

        // decrement with overlapping increment in S_HOUR
        cyc(0, 0, 1, 0, 0, SH, 0, 0, 0, "to_hour");
        idle(SH, "hour_idle");
        for (int k = 0; k < 10; k++) begin
            t = (k + 1 == 1) || (k + 1 == 8);
            cyc(0, 0, 0, (k == 5 || k == 6), 1, SH, t, 0, t, "dec_ovl");
        end
        for (int k = 0; k < 2; k++) idle(SH, "dec_rel");

        // idle timeout
        cyc(0, 1, 0, 0, 0, SR, 0, 0, 0, "leave");
        cyc(0, 1, 0, 0, 0, SS, 0, 0, 0, "enter3");
        for (int k = 0; k < 20; k++)
            idle((k + 1 < 20) ? SS : SR, "timeout");
        idle(SR, "after_to");

        // timeout restarted by a press at cycle 10
        cyc(0, 1, 0, 0, 0, SS, 0, 0, 0, "enter4");
        for (int k = 0; k < 33; k++) begin
            t = (k + 1 == 11);
            cyc(0, 0, 0, (k == 10), 0, (k + 1 < 31) ? SS : SR,
                t, 1, t, "to_restart");
        end

        // mode pulse in the timeout cycle stays in run
        cyc(0, 1, 0, 0, 0, SS, 0, 0, 0, "enter5");
        for (int k = 0; k < 19; k++) idle(SS, "to_wait");
        cyc(0, 1, 0, 0, 0, SR, 0, 0, 0, "to_mode");
        idle(SR, "to_mode_run");
        idle(SR, "to_mode_run2");

        // reset during auto-repeat in S_YEAR
        cyc(0, 1, 0, 0, 0, SS, 0, 0, 0, "enter6");
        cyc(0, 0, 1, 0, 0, SM, 0, 0, 0, "y1");
        cyc(0, 0, 1, 0, 0, SH, 0, 0, 0, "y2");
        cyc(0, 0, 1, 0, 0, SD, 0, 0, 0, "y3");
        cyc(0, 0, 1, 0, 0, SO, 0, 0, 0, "y4");
        cyc(0, 0, 1, 0, 0, SY, 0, 0, 0, "y5");
        for (int k = 0; k < 13; k++) begin
            t = in_set(k + 1, yr_ticks);
            cyc(0, 0, 0, 1, 0, SY, t, 1, t, "yr_hold");
        end
        cyc(1, 0, 0, 1, 0, SR, 0, 1, 1, "rst_mid");
        for (int k = 0; k < 10; k++)
            cyc(0, 0, 0, 1, 0, SR, 0, 1, 1, "run_inc");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
